// File: rtl/spi_tx_arbiter_if.sv
// Byte-stream handshake bundle between the two requesters, the arbiter and the SPI master.
// The slave modport is the arbiter's view; the master modport drives requests and m_ready.
interface spi_tx_arbiter_if;
  logic       a_valid;
  logic       a_ready;
  logic [7:0] a_byte;
  logic       a_last;
  logic       b_valid;
  logic       b_ready;
  logic [7:0] b_byte;
  logic       b_last;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_byte;
  logic       m_clear_cs;
  logic [1:0] owner;

  modport slave (
    input  a_valid, a_byte, a_last,
    input  b_valid, b_byte, b_last,
    input  m_ready,
    output a_ready, b_ready,
    output m_valid, m_byte, m_clear_cs, owner
  );

  modport master (
    output a_valid, a_byte, a_last,
    output b_valid, b_byte, b_last,
    output m_ready,
    input  a_ready, b_ready,
    input  m_valid, m_byte, m_clear_cs, owner
  );
endinterface

// File: rtl/spi_tx_arbiter.sv
// Round-robin sharing of one SPI byte transmitter between two requesters, locked per
// transaction so chip-select framing never interleaves. One-entry output buffer.
module spi_tx_arbiter (
  input  logic             clock,
  input  logic             reset_async,
  spi_tx_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_OWN_A   = 3'd1,
    S_OWN_B   = 3'd2,
    S_DRAIN_A = 3'd3,
    S_DRAIN_B = 3'd4
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic       r_rr;
  logic       w_rr_next;
  logic [1:0] r_rst_sync;
  logic       w_rst_hold;
  logic       r_full;
  logic [7:0] r_byte;
  logic       r_last;
  logic       w_load;
  logic [7:0] w_load_byte;
  logic       w_load_last;
  logic       w_drain;
  logic       w_a_ready;
  logic       w_b_ready;
  logic [1:0] w_owner;

  // Assertion is immediate; release is seen only after two clean edges.
  always_ff @(posedge clock or posedge reset_async) begin
    if (reset_async) begin
      r_rst_sync <= 2'b11;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b0};
    end
  end

  assign w_rst_hold = r_rst_sync[1];
  assign w_drain    = r_full && bus.m_ready;

  always_ff @(posedge clock or posedge reset_async) begin
    if (reset_async) begin
      r_state <= S_IDLE;
      r_rr    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_rr    <= w_rr_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_rr_next    = r_rr;
    w_a_ready    = 1'b0;
    w_b_ready    = 1'b0;
    w_load       = 1'b0;
    w_load_byte  = 8'h00;
    w_load_last  = 1'b0;
    w_owner      = 2'b00;
    case (r_state)
      S_IDLE: begin
        if (bus.a_valid && (!bus.b_valid || !r_rr)) begin
          w_state_next = S_OWN_A;
        end else if (bus.b_valid) begin
          w_state_next = S_OWN_B;
        end
      end
      S_OWN_A: begin
        w_owner   = 2'b01;
        w_a_ready = !r_full;
        if (bus.a_valid && !r_full) begin
          w_load      = 1'b1;
          w_load_byte = bus.a_byte;
          w_load_last = bus.a_last;
          if (bus.a_last) begin
            w_state_next = S_DRAIN_A;
            w_rr_next    = 1'b1;
          end
        end
      end
      S_OWN_B: begin
        w_owner   = 2'b10;
        w_b_ready = !r_full;
        if (bus.b_valid && !r_full) begin
          w_load      = 1'b1;
          w_load_byte = bus.b_byte;
          w_load_last = bus.b_last;
          if (bus.b_last) begin
            w_state_next = S_DRAIN_B;
            w_rr_next    = 1'b0;
          end
        end
      end
      S_DRAIN_A: begin
        w_owner = 2'b01;
        if (w_drain) w_state_next = S_IDLE;
      end
      S_DRAIN_B: begin
        w_owner = 2'b10;
        if (w_drain) w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
    // Only IDLE is reachable while the reset release is still synchronising.
    if (w_rst_hold) begin
      w_state_next = S_IDLE;
    end
  end

  // Loads only happen when empty, so load and drain never coincide.
  always_ff @(posedge clock or posedge reset_async) begin
    if (reset_async) begin
      r_full <= 1'b0;
      r_byte <= 8'h00;
      r_last <= 1'b0;
    end else if (w_load) begin
      r_full <= 1'b1;
      r_byte <= w_load_byte;
      r_last <= w_load_last;
    end else if (w_drain) begin
      r_full <= 1'b0;
    end
  end

  assign bus.a_ready    = w_a_ready;
  assign bus.b_ready    = w_b_ready;
  assign bus.m_valid    = r_full;
  assign bus.m_byte     = r_byte;
  assign bus.m_clear_cs = r_last;
  assign bus.owner      = w_owner;

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Directed bench for spi_tx_arbiter: expected bytes are queued by the stimulus,
// a negedge monitor pops and compares every transfer to the master.
module tb_spi_tx_arbiter;

  logic clock = 1'b0;
  logic reset_async;
  always #5 clock = ~clock;

  spi_tx_arbiter_if bus ();

  spi_tx_arbiter dut (
    .clock       (clock),
    .reset_async (reset_async),
    .bus         (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit aborted = 0;
  logic [8:0] exp_q[$];

  int gap_min = 1000;
  int low_cnt = 0;
  bit after_last = 0;
  int lasts = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: inputs change just after posedge, so negedge shows what the next edge transfers.
  always @(negedge clock) begin
    if (!reset_async && bus.m_valid) begin
      if (after_last) begin
        if (low_cnt < gap_min) gap_min = low_cnt;
        after_last = 0;
      end
      if (bus.m_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_xfer: got byte %02h last %0b, expected no transfer", bus.m_byte, bus.m_clear_cs);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          chk("xfer", {23'd0, bus.m_clear_cs, bus.m_byte}, {23'd0, e});
          $display("xfer byte=%02h last=%0b owner=%0d", bus.m_byte, bus.m_clear_cs, bus.owner);
        end
        if (bus.m_clear_cs) begin
          after_last = 1;
          low_cnt = 0;
          lasts++;
        end
      end
    end else if (after_last) begin
      low_cnt++;
    end
  end

  task automatic send(input bit port_b, input logic [7:0] d, input logic l);
    int t;
    bit ok;
    if (aborted) return;
    if (port_b) begin
      bus.b_valid = 1'b1; bus.b_byte = d; bus.b_last = l;
    end else begin
      bus.a_valid = 1'b1; bus.a_byte = d; bus.a_last = l;
    end
    ok = 0;
    t = 0;
    while (!ok && t < 200) begin
      @(negedge clock);
      if (port_b ? bus.b_ready : bus.a_ready) ok = 1;
      @(posedge clock);
      #1;
      t++;
    end
    if (port_b) bus.b_valid = 1'b0;
    else        bus.a_valid = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_err++;
      aborted = 1;
      $display("FAIL send_timeout: port %0d byte %02h got no ready, expected ready within 200 cycles", port_b, d);
    end
  endtask

  task automatic wait_quiet(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || bus.owner != 2'b00 || bus.m_valid) && t < 200) begin
      @(posedge clock);
      #1;
      t++;
    end
    if (t >= 200) begin
      n_cmp++;
      n_err++;
      aborted = 1;
      $display("FAIL %s_timeout: got %0d bytes pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    #2 reset_async = 1'b1;
    @(posedge clock);
    #3 reset_async = 1'b0;
    repeat (3) @(posedge clock);
    #1;
  endtask

  initial begin
    int t;
    bit bad;
    reset_async = 1'b1;
    bus.a_valid = 0; bus.a_byte = 0; bus.a_last = 0;
    bus.b_valid = 0; bus.b_byte = 0; bus.b_last = 0;
    bus.m_ready = 0;
    repeat (2) @(posedge clock);
    #3 reset_async = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_owner", {30'd0, bus.owner}, 32'd0);
    chk("rst_m_valid", {31'd0, bus.m_valid}, 32'd0);
    chk("rst_m_byte", {24'd0, bus.m_byte}, 32'd0);
    chk("rst_m_clear_cs", {31'd0, bus.m_clear_cs}, 32'd0);
    chk("rst_a_ready", {31'd0, bus.a_ready}, 32'd0);
    chk("rst_b_ready", {31'd0, bus.b_ready}, 32'd0);

    // Test 1: async reset while OWN_A holds 0x5A.
    bus.a_valid = 1; bus.a_byte = 8'h5A; bus.a_last = 0;
    t = 0;
    while (!bus.m_valid && t < 20) begin
      @(posedge clock); #1; t++;
    end
    chk("t1_owner_before", {30'd0, bus.owner}, 32'd1);
    chk("t1_buf_before", {24'd0, bus.m_byte}, 32'h5A);
    #2 reset_async = 1'b1;
    #1;
    chk("t1_async_m_valid", {31'd0, bus.m_valid}, 32'd0);
    chk("t1_async_owner", {30'd0, bus.owner}, 32'd0);
    chk("t1_async_a_ready", {31'd0, bus.a_ready}, 32'd0);
    chk("t1_async_b_ready", {31'd0, bus.b_ready}, 32'd0);
    #2 reset_async = 1'b0;
    bus.a_byte = 8'h26; bus.m_ready = 1;
    exp_q.push_back({1'b0, 8'h26});
    exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b1, 8'hE3});
    @(posedge clock); #1;
    chk("t1_rel_edge1_owner", {30'd0, bus.owner}, 32'd0);
    @(posedge clock); #1;
    chk("t1_rel_edge2_owner", {30'd0, bus.owner}, 32'd0);
    @(posedge clock); #1;
    chk("t1_rel_edge3_owner", {30'd0, bus.owner}, 32'd1);
    chk("t1_rel_edge3_a_ready", {31'd0, bus.a_ready}, 32'd1);

    // Test 2: single A transaction with m_ready high.
    send(0, 8'h26, 0);
    chk("t2_owner_b0", {30'd0, bus.owner}, 32'd1);
    send(0, 8'h11, 0);
    chk("t2_owner_b1", {30'd0, bus.owner}, 32'd1);
    send(0, 8'hE3, 1);
    chk("t2_drain_owner", {30'd0, bus.owner}, 32'd1);
    chk("t2_drain_byte", {23'd0, bus.m_clear_cs, bus.m_byte}, {23'd0, 1'b1, 8'hE3});
    chk("t2_drain_a_ready", {31'd0, bus.a_ready}, 32'd0);
    @(posedge clock); #1;
    chk("t2_release_owner", {30'd0, bus.owner}, 32'd0);
    chk("t2_release_m_valid", {31'd0, bus.m_valid}, 32'd0);
    wait_quiet("t2");

    // Test 3: simultaneous requests, A first after reset; B first once rr points at B.
    do_reset();
    exp_q.push_back({1'b0, 8'h31}); exp_q.push_back({1'b1, 8'h32});
    exp_q.push_back({1'b0, 8'h41}); exp_q.push_back({1'b1, 8'h42});
    fork
      begin send(0, 8'h31, 0); send(0, 8'h32, 1); end
      begin send(1, 8'h41, 0); send(1, 8'h42, 1); end
    join
    wait_quiet("t3a");
    exp_q.push_back({1'b1, 8'h51});
    send(0, 8'h51, 1);
    wait_quiet("t3b");
    exp_q.push_back({1'b0, 8'h61}); exp_q.push_back({1'b1, 8'h62});
    exp_q.push_back({1'b0, 8'h71}); exp_q.push_back({1'b1, 8'h72});
    fork
      begin send(0, 8'h71, 0); send(0, 8'h72, 1); end
      begin send(1, 8'h61, 0); send(1, 8'h62, 1); end
    join
    wait_quiet("t3c");

    // Test 4: B waits behind A's locked, paused transaction.
    exp_q.push_back({1'b0, 8'h81}); exp_q.push_back({1'b0, 8'h82});
    exp_q.push_back({1'b1, 8'h83}); exp_q.push_back({1'b1, 8'h99});
    bad = 0;
    fork
      begin
        send(0, 8'h81, 0);
        send(0, 8'h82, 0);
        repeat (50) begin
          @(posedge clock); #1;
          if (bus.b_ready) bad = 1;
        end
        chk("t4_lock_b_ready", {31'd0, bad}, 32'd0);
        chk("t4_lock_owner", {30'd0, bus.owner}, 32'd1);
        send(0, 8'h83, 1);
      end
      begin
        repeat (6) @(posedge clock);
        #1;
        send(1, 8'h99, 1);
      end
    join
    wait_quiet("t4");

    // Test 5: 20-cycle backpressure with 0x42 buffered and the next byte waiting.
    bus.m_ready = 0;
    exp_q.push_back({1'b0, 8'h42}); exp_q.push_back({1'b1, 8'h43});
    send(0, 8'h42, 0);
    bus.a_valid = 1; bus.a_byte = 8'h43; bus.a_last = 1;
    bad = 0;
    t = 0;
    repeat (20) begin
      if (!bus.m_valid || bus.m_byte != 8'h42 || bus.m_clear_cs) bad = 1;
      if (bus.a_ready) t++;
      @(posedge clock); #1;
    end
    chk("t5_stall_stable", {31'd0, bad}, 32'd0);
    chk("t5_stall_a_ready_cycles", t, 32'd0);
    chk("t5_stall_queue", exp_q.size(), 32'd2);
    bus.m_ready = 1;
    send(0, 8'h43, 1);
    wait_quiet("t5");

    // Test 6: two back-to-back 65-byte frames from A.
    gap_min = 1000;
    after_last = 0;
    lasts = 0;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 65; i++) begin
        exp_q.push_back({i == 64, 8'(f * 65 + i)});
      end
    end
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 65; i++) begin
        send(0, 8'(f * 65 + i), i == 64);
      end
    end
    wait_quiet("t6");
    chk("t6_last_count", lasts, 32'd2);
    chk("t6_gap_at_least_2", {31'd0, gap_min >= 2 && gap_min < 1000}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
